risc_multicycle_cu: RTL and testbench

- Parametrised multi-cycle control unit for the 16-bit RISC core; replaces single-cycle combinational decode.
- An FSM sequences fetch, decode, execute, memory and writeback over several cycles. It handshakes with instruction and data memory, folds ALU-select decode in, and flags illegal opcodes and memory timeouts.
- Sits between the instruction/data memory interfaces and the datapath (PC, IR, GPR file, ALU).

---
 rtl/risc16_pkg.sv | 39 +++
 rtl/risc_multicycle_cu_if.sv | 40 ++++
 rtl/risc_wait_timer.sv | 31 +++
 rtl/risc_multicycle_cu.sv | 184 ++++++++++++++++++
 tb/tb_risc_multicycle_cu.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc16_pkg.sv
// Shared constants for the 16-bit RISC multi-cycle control unit:
// opcodes, FSM state encoding, PC-source and fault codes.
package risc16_pkg;

    localparam int OP_LW        = 0;
    localparam int OP_SW        = 1;
    localparam int OP_ALU_FIRST = 2;
    localparam int OP_ALU_LAST  = 10;
    localparam int OP_BEQ       = 11;
    localparam int OP_BNE       = 12;
    localparam int OP_JMP       = 13;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM    = 4'd5,
        ST_WB     = 4'd6,
        ST_BRANCH = 4'd7,
        ST_JUMP   = 4'd8,
        ST_TRAP   = 4'd9
    } state_e;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    // ALU ops wrap modulo 8, so the last ALU opcode aliases select 000.
    function automatic logic [2:0] alu_sel_of(input int unsigned opc);
        return 3'(opc - OP_ALU_FIRST);
    endfunction

endpackage

// File: rtl/risc_multicycle_cu_if.sv
// Control-unit bus: memory handshakes and datapath control strobes.
// master = control unit, slave = memories/datapath side.
interface risc_multicycle_cu_if #(
    parameter int INSTR_W = 16
);
    logic [INSTR_W-1:0] i_instr;
    logic               i_instr_valid;
    logic               i_mem_ready;
    logic               i_zero;

    logic               o_instr_req;
    logic               o_ir_wr;
    logic               o_pc_wr;
    logic [1:0]         o_pc_src;
    logic               o_reg_dst;
    logic               o_reg_wr;
    logic               o_alu_src;
    logic               o_mem_to_reg;
    logic               o_mem_rd;
    logic               o_mem_wr;
    logic [2:0]         o_alu_sel;
    logic               o_fault;
    logic [1:0]         o_fault_code;
    logic [3:0]         o_state;

    modport master (
        input  i_instr, i_instr_valid, i_mem_ready, i_zero,
        output o_instr_req, o_ir_wr, o_pc_wr, o_pc_src, o_reg_dst, o_reg_wr,
               o_alu_src, o_mem_to_reg, o_mem_rd, o_mem_wr, o_alu_sel,
               o_fault, o_fault_code, o_state
    );

    modport slave (
        output i_instr, i_instr_valid, i_mem_ready, i_zero,
        input  o_instr_req, o_ir_wr, o_pc_wr, o_pc_src, o_reg_dst, o_reg_wr,
               o_alu_src, o_mem_to_reg, o_mem_rd, o_mem_wr, o_alu_sel,
               o_fault, o_fault_code, o_state
    );

endinterface

// File: rtl/risc_wait_timer.sv
// Saturating wait counter; expired_o flags that LIMIT wait cycles have
// already elapsed in the current state.
module risc_wait_timer #(
    parameter int W     = 4,
    parameter int LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/risc_multicycle_cu.sv
// Multi-cycle control FSM for the 16-bit RISC core: fetch/decode/execute/
// memory/writeback sequencing with illegal-opcode and memory-timeout traps.
module risc_multicycle_cu #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int TMO_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    risc_multicycle_cu_if.master bus
);
    import risc16_pkg::*;

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;

    logic tmr_en, tmr_clr, tmr_exp;
    logic is_lw, is_sw, is_alu, is_beq, is_bne, is_jmp;
    logic [2:0] op_alu_sel;

    logic       instr_req, ir_wr, pc_wr, reg_dst, reg_wr, alu_src;
    logic       mem_to_reg, mem_rd, mem_wr;
    logic [1:0] pc_src;
    logic [2:0] alu_sel;

    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.i_instr[INSTR_W-OPC_W-1:0];

    assign is_lw  = (opc_q == OPC_W'(OP_LW));
    assign is_sw  = (opc_q == OPC_W'(OP_SW));
    assign is_alu = (opc_q >= OPC_W'(OP_ALU_FIRST)) && (opc_q <= OPC_W'(OP_ALU_LAST));
    assign is_beq = (opc_q == OPC_W'(OP_BEQ));
    assign is_bne = (opc_q == OPC_W'(OP_BNE));
    assign is_jmp = (opc_q == OPC_W'(OP_JMP));
    assign op_alu_sel = alu_sel_of(32'(opc_q));

    // Any state change restarts the wait budget for the new state.
    assign tmr_clr = (state_d != state_q);

    risc_wait_timer #(.W(TMO_W), .LIMIT(TIMEOUT)) u_timer (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        fault_d    = fault_q;
        code_d     = code_q;
        tmr_en     = 1'b0;
        instr_req  = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = PC_SRC_SEQ;
        reg_dst    = 1'b0;
        reg_wr     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        alu_sel    = 3'b000;

        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                instr_req = 1'b1;
                if (bus.i_instr_valid) begin
                    ir_wr   = 1'b1;
                    opc_d   = bus.i_instr[INSTR_W-1 -: OPC_W];
                    state_d = ST_DECODE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_exp) begin
                        state_d = ST_TRAP;
                        fault_d = 1'b1;
                        code_d  = FLT_TIMEOUT;
                    end
                end
            end
            ST_DECODE: begin
                if (is_lw || is_sw)        state_d = ST_ADDR;
                else if (is_alu)           state_d = ST_EXEC;
                else if (is_beq || is_bne) state_d = ST_BRANCH;
                else if (is_jmp)           state_d = ST_JUMP;
                else begin
                    state_d = ST_TRAP;
                    fault_d = 1'b1;
                    code_d  = FLT_ILLEGAL;
                end
            end
            ST_EXEC: begin
                reg_dst = 1'b1;
                alu_sel = op_alu_sel;
                state_d = ST_WB;
            end
            ST_ADDR: begin
                alu_src = 1'b1;
                state_d = ST_MEM;
            end
            ST_MEM: begin
                alu_src = 1'b1;
                mem_rd  = is_lw;
                mem_wr  = is_sw;
                if (bus.i_mem_ready) begin
                    if (is_lw) begin
                        state_d = ST_WB;
                    end else begin
                        pc_wr   = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_exp) begin
                        state_d = ST_TRAP;
                        fault_d = 1'b1;
                        code_d  = FLT_TIMEOUT;
                    end
                end
            end
            ST_WB: begin
                reg_wr = 1'b1;
                pc_wr  = 1'b1;
                if (is_lw) begin
                    mem_to_reg = 1'b1;
                    alu_src    = 1'b1;
                end else begin
                    reg_dst = 1'b1;
                    alu_sel = op_alu_sel;
                end
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_sel = 3'b001;
                pc_wr   = 1'b1;
                if ((is_beq && bus.i_zero) || (is_bne && !bus.i_zero))
                    pc_src = PC_SRC_BR;
                state_d = ST_FETCH;
            end
            ST_JUMP: begin
                pc_wr   = 1'b1;
                pc_src  = PC_SRC_JMP;
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            opc_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= FLT_NONE;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign bus.o_instr_req  = instr_req;
    assign bus.o_ir_wr      = ir_wr;
    assign bus.o_pc_wr      = pc_wr;
    assign bus.o_pc_src     = pc_src;
    assign bus.o_reg_dst    = reg_dst;
    assign bus.o_reg_wr     = reg_wr;
    assign bus.o_alu_src    = alu_src;
    assign bus.o_mem_to_reg = mem_to_reg;
    assign bus.o_mem_rd     = mem_rd;
    assign bus.o_mem_wr     = mem_wr;
    assign bus.o_alu_sel    = alu_sel;
    assign bus.o_fault      = fault_q;
    assign bus.o_fault_code = code_q;
    assign bus.o_state      = state_q;

endmodule

// File: tb/tb_risc_multicycle_cu.sv
// Bench for risc_multicycle_cu: per-instruction transaction summaries checked
// against a table and an instruction-level model, plus hand-written corner cases.
module tb_risc_multicycle_cu;

    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc_multicycle_cu_if #(.INSTR_W(16)) bus();

    risc_multicycle_cu #(
        .INSTR_W(16), .OPC_W(4), .TMO_W(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Instruction-level summary; -1 marks "not observed / don't care".
    typedef struct {
        int cycles;
        int reg_wr_n;
        int pc_wr_n;
        int pc_src;
        int alu_sel;
        int rd_n;
        int wr_n;
        int m2r;
        int rdst;
    } res_t;

    typedef struct {
        logic [15:0] instr;
        int          fw;
        int          mw;
        bit          zero;
        res_t        exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.i_instr_valid = 1'b0;
        bus.i_mem_ready   = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_reset_fetch", int'(bus.o_state), 1);
    endtask

    // Acts as instruction/data memory for one instruction starting in FETCH,
    // and summarises the strobes it observed until the next FETCH or TRAP.
    task automatic run_instr(input logic [15:0] instr, input int fw, input int mw,
                             input bit zero, output res_t r);
        int  fcnt = 0;
        int  mcnt = 0;
        bit  left = 1'b0;
        bit  done = 1'b0;
        r.cycles = 0; r.reg_wr_n = 0; r.pc_wr_n = 0; r.pc_src = -1; r.alu_sel = -1;
        r.rd_n = 0; r.wr_n = 0; r.m2r = -1; r.rdst = -1;
        for (int c = 0; c < 100 && !done; c++) begin
            bus.i_instr       = instr;
            bus.i_zero        = zero;
            bus.i_instr_valid = (bus.o_state == 4'd1) && (fcnt >= fw);
            bus.i_mem_ready   = (bus.o_state == 4'd5) && (mcnt >= mw);
            #1;
            r.cycles++;
            if (bus.o_state == 4'd1) fcnt++;
            if (bus.o_mem_rd || bus.o_mem_wr) mcnt++;
            r.rd_n += int'(bus.o_mem_rd);
            r.wr_n += int'(bus.o_mem_wr);
            chk("mem_rd_wr_exclusive", int'(bus.o_mem_rd && bus.o_mem_wr), 0);
            chk("reg_wr_only_in_wb", int'(bus.o_reg_wr && (bus.o_state != 4'd6)), 0);
            if (bus.o_reg_wr) begin
                r.reg_wr_n++;
                r.m2r  = int'(bus.o_mem_to_reg);
                r.rdst = int'(bus.o_reg_dst);
            end
            if (bus.o_pc_wr) begin
                r.pc_wr_n++;
                r.pc_src  = int'(bus.o_pc_src);
                r.alu_sel = int'(bus.o_alu_sel);
            end
            @(posedge clk);
            #1;
            if (bus.o_state == 4'd9) done = 1'b1;
            else if (bus.o_state != 4'd1) left = 1'b1;
            else if (left) done = 1'b1;
        end
        bus.i_instr_valid = 1'b0;
        bus.i_mem_ready   = 1'b0;
        if (!done) chk("instr_cycle_budget", 0, 1);
    endtask

    task automatic cmp_res(input string tag, input res_t r, input res_t e);
        chk({tag, ".cycles"},   r.cycles,   e.cycles);
        chk({tag, ".reg_wr_n"}, r.reg_wr_n, e.reg_wr_n);
        chk({tag, ".pc_wr_n"},  r.pc_wr_n,  e.pc_wr_n);
        chk({tag, ".pc_src"},   r.pc_src,   e.pc_src);
        chk({tag, ".mem_rd_n"}, r.rd_n,     e.rd_n);
        chk({tag, ".mem_wr_n"}, r.wr_n,     e.wr_n);
        if (e.alu_sel >= 0) chk({tag, ".alu_sel"}, r.alu_sel, e.alu_sel);
        if (e.m2r >= 0) begin
            chk({tag, ".mem_to_reg"}, r.m2r,  e.m2r);
            chk({tag, ".reg_dst"},    r.rdst, e.rdst);
        end
    endtask

    // Reference: instruction classes and their cycle/strobe budgets.
    function automatic res_t model(input int opc, input int fw, input int mw, input bit zero);
        res_t e;
        e.reg_wr_n = 0; e.pc_wr_n = 1; e.pc_src = 0; e.alu_sel = -1;
        e.rd_n = 0; e.wr_n = 0; e.m2r = -1; e.rdst = -1;
        if (opc == 0) begin
            e.cycles = fw + 5 + mw; e.reg_wr_n = 1; e.rd_n = mw + 1; e.m2r = 1; e.rdst = 0;
        end else if (opc == 1) begin
            e.cycles = fw + 4 + mw; e.wr_n = mw + 1;
        end else if (opc <= 10) begin
            e.cycles = fw + 4; e.reg_wr_n = 1; e.alu_sel = (opc - 2) % 8; e.m2r = 0; e.rdst = 1;
        end else if (opc <= 12) begin
            e.cycles = fw + 3; e.alu_sel = 1;
            if ((opc == 11 && zero) || (opc == 12 && !zero)) e.pc_src = 1;
        end else begin
            e.cycles = fw + 3; e.pc_src = 2;
        end
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        res_t r;
        int   alu_states[4];

        vecs[0]  = '{16'h0283, 0, 3,  1'b0, '{8,  1, 1, 0, -1, 4,  0, 1,  0}};
        vecs[1]  = '{16'hB281, 0, 0,  1'b1, '{3,  0, 1, 1, 1,  0,  0, -1, -1}};
        vecs[2]  = '{16'hC281, 0, 0,  1'b1, '{3,  0, 1, 0, 1,  0,  0, -1, -1}};
        vecs[3]  = '{16'hD123, 0, 0,  1'b0, '{3,  0, 1, 2, -1, 0,  0, -1, -1}};
        vecs[4]  = '{16'h1044, 2, 2,  1'b0, '{8,  0, 1, 0, -1, 0,  3, -1, -1}};
        vecs[5]  = '{16'h9ABC, 0, 0,  1'b0, '{4,  1, 1, 0, 7,  0,  0, 0,  1}};
        vecs[6]  = '{16'hA000, 1, 0,  1'b0, '{5,  1, 1, 0, 0,  0,  0, 0,  1}};
        vecs[7]  = '{16'h0000, 0, 15, 1'b0, '{20, 1, 1, 0, -1, 16, 0, 1,  0}};
        vecs[8]  = '{16'h3FFF, 14, 0, 1'b0, '{18, 1, 1, 0, 1,  0,  0, 0,  1}};
        vecs[9]  = '{16'hC000, 0, 0,  1'b0, '{3,  0, 1, 1, 1,  0,  0, -1, -1}};
        vecs[10] = '{16'hB000, 0, 0,  1'b0, '{3,  0, 1, 0, 1,  0,  0, -1, -1}};
        alu_states = '{1, 2, 3, 6};

        bus.i_instr = 16'h0; bus.i_instr_valid = 1'b0;
        bus.i_mem_ready = 1'b0; bus.i_zero = 1'b0;
        rst = 1'b1;
        #12;
        chk("reset.state", int'(bus.o_state), 0);
        chk("reset.outputs", int'({bus.o_instr_req, bus.o_ir_wr, bus.o_pc_wr, bus.o_pc_src,
            bus.o_reg_dst, bus.o_reg_wr, bus.o_alu_src, bus.o_mem_to_reg, bus.o_mem_rd,
            bus.o_mem_wr, bus.o_alu_sel}), 0);
        chk("reset.fault", int'({bus.o_fault, bus.o_fault_code}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle_after_release", int'(bus.o_state), 0);
        cyc();
        chk("fetch_after_idle", int'(bus.o_state), 1);
        chk("fetch.instr_req", int'(bus.o_instr_req), 1);

        // ALU op: exact state walk and writeback strobes.
        bus.i_instr = 16'h2A50;
        bus.i_instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("alu_trace[%0d]", i), int'(bus.o_state), alu_states[i]);
            if (i == 0) chk("alu.ir_wr", int'(bus.o_ir_wr), 1);
            if (i == 3) begin
                chk("alu_wb.reg_wr",  int'(bus.o_reg_wr), 1);
                chk("alu_wb.reg_dst", int'(bus.o_reg_dst), 1);
                chk("alu_wb.alu_sel", int'(bus.o_alu_sel), 0);
                chk("alu_wb.pc_wr",   int'(bus.o_pc_wr), 1);
                chk("alu_wb.pc_src",  int'(bus.o_pc_src), 0);
            end
            cyc();
            bus.i_instr_valid = 1'b0;
        end
        chk("alu_trace[4]", int'(bus.o_state), 1);

        for (int i = 0; i < 11; i++) begin
            run_instr(vecs[i].instr, vecs[i].fw, vecs[i].mw, vecs[i].zero, r);
            cmp_res($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            int          opc;
            int          fw;
            int          mw;
            bit          z;
            logic [15:0] ins;
            opc = int'($urandom_range(13, 0));
            fw  = int'($urandom_range(5, 0));
            mw  = int'($urandom_range(6, 0));
            z   = 1'($urandom_range(1, 0));
            ins = {4'(opc), 12'($urandom)};
            run_instr(ins, fw, mw, z, r);
            cmp_res($sformatf("rnd%0d", i), r, model(opc, fw, mw, z));
        end

        // Illegal opcode traps and stays trapped.
        run_instr(16'hE000, 0, 0, 1'b0, r);
        chk("illegal.cycles", r.cycles, 2);
        for (int i = 0; i < 3; i++) begin
            chk("illegal.state", int'(bus.o_state), 9);
            chk("illegal.fault", int'(bus.o_fault), 1);
            chk("illegal.code", int'(bus.o_fault_code), 1);
            chk("illegal.instr_req", int'(bus.o_instr_req), 0);
            cyc();
        end

        // Store with data memory never ready: full wait budget then timeout trap.
        do_reset();
        run_instr(16'h1000, 0, 1000, 1'b0, r);
        chk("sw_tmo.mem_wr_cycles", r.wr_n, TIMEOUT + 1);
        chk("sw_tmo.cycles", r.cycles, 3 + TIMEOUT + 1);
        chk("sw_tmo.state", int'(bus.o_state), 9);
        chk("sw_tmo.code", int'(bus.o_fault_code), 2);
        chk("sw_tmo.fault", int'(bus.o_fault), 1);
        chk("sw_tmo.mem_wr", int'(bus.o_mem_wr), 0);

        // Instruction memory never valid: fetch timeout.
        do_reset();
        run_instr(16'h2000, 1000, 0, 1'b0, r);
        chk("fetch_tmo.cycles", r.cycles, TIMEOUT + 1);
        chk("fetch_tmo.state", int'(bus.o_state), 9);
        chk("fetch_tmo.code", int'(bus.o_fault_code), 2);

        // Reset asserted mid-MEM drops the store strobe without a clock edge.
        do_reset();
        bus.i_instr = 16'h1000;
        bus.i_instr_valid = 1'b1;
        cyc();
        bus.i_instr_valid = 1'b0;
        cyc();
        cyc();
        chk("rst_mem.in_mem", int'(bus.o_state), 5);
        chk("rst_mem.mem_wr_before", int'(bus.o_mem_wr), 1);
        cyc();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mem.mem_wr_async", int'(bus.o_mem_wr), 0);
        chk("rst_mem.state_async", int'(bus.o_state), 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_mem.idle_after_release", int'(bus.o_state), 0);
        cyc();
        chk("rst_mem.fetch_next", int'(bus.o_state), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
